// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and drain controller feeding a transmit-only UART
// Host bytes are buffered here and released one per UART write/busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [7:0]            data,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_wr,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, HOLD} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  state_t                state;
  state_t                state_nxt;
  logic                  push;
  logic                  pop;

  // Flags come from the registered count only, so pointer equality never matters.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr & ~full & ~flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // HOLD masks the cycle before the UART reflects the accepted write on tx_busy.
  always_comb begin
    pop = 1'b0;
    if (state == IDLE) pop = ~empty & ~tx_busy & ~flush;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_wr    <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_wr <= pop;
      if (pop) tx_data <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
      if (wr && full && !flush) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo
// Expected bytes are queued when accepted and popped on every tx_wr pulse.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset, wr, flush, clr_overflow;
  logic [7:0] data;
  logic       full, empty, overflow, tx_wr, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       uart_en, rand_busy, busy_manual;
  int         model_cnt;
  logic       prev_wr, prev_busy;
  int         n_cmp, n_err, n_pulse;
  logic [7:0] q[$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .wr(wr), .data(data), .flush(flush),
    .clr_overflow(clr_overflow), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // UART model: busy rises the cycle after accepting tx_wr.
  always @(posedge clk) begin
    if (reset || !uart_en) model_cnt <= 0;
    else if (tx_wr)        model_cnt <= rand_busy ? int'($urandom_range(0, 3)) : 20;
    else if (model_cnt > 0) model_cnt <= model_cnt - 1;
  end
  assign tx_busy = uart_en ? (model_cnt != 0) : busy_manual;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && tx_wr) begin
      n_pulse++;
      chk("single_cycle_pulse", {31'd0, prev_wr}, 32'd0);
      chk("busy_low_before_pulse", {31'd0, prev_busy}, 32'd0);
      if (q.size() == 0) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_tx_wr observed=%0h expected=none", tx_data);
        end
      end else begin
        chk("tx_data_order", {24'd0, tx_data}, {24'd0, q.pop_front()});
      end
    end
    prev_wr   = tx_wr;
    prev_busy = tx_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      data = first + 8'(i);
      q.push_back(data);
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && (q.size() != 0 || count != 0); i++) tick();
    chk("drain_queue", q.size(), 0);
    chk("drain_count", {27'd0, count}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_txwr(input int max);
    for (int i = 0; i < max && !tx_wr; i++) tick();
    chk("tx_wr_seen", {31'd0, tx_wr}, 32'd1);
  endtask

  initial begin
    int sent;
    n_cmp = 0; n_err = 0; n_pulse = 0;
    prev_wr = 1'b0; prev_busy = 1'b0;
    reset = 1'b1; wr = 1'b0; data = 8'h00; flush = 1'b0; clr_overflow = 1'b0;
    uart_en = 1'b0; rand_busy = 1'b0; busy_manual = 1'b0;
    tick(); tick();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;

    // Single byte latency
    wr = 1'b1; data = 8'h41; q.push_back(8'h41);
    tick(); wr = 1'b0;
    chk("lat_count_n1", {27'd0, count}, 32'd1);
    chk("lat_tx_wr_n1", {31'd0, tx_wr}, 32'd0);
    tick();
    chk("lat_tx_wr_n2", {31'd0, tx_wr}, 32'd1);
    chk("lat_tx_data_n2", {24'd0, tx_data}, 32'h41);
    tick();
    chk("lat_tx_wr_n3", {31'd0, tx_wr}, 32'd0);
    chk("lat_count_n3", {27'd0, count}, 32'd0);
    chk("lat_empty_n3", {31'd0, empty}, 32'd1);
    tick();

    // Fill to full, overflow on the 17th byte
    busy_manual = 1'b1;
    push_run(8'h30, 16);
    chk("burst_full", {31'd0, full}, 32'd1);
    chk("burst_count", {27'd0, count}, 32'd16);
    chk("burst_no_tx", {31'd0, tx_wr}, 32'd0);
    wr = 1'b1; data = 8'h40; tick(); wr = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {27'd0, count}, 32'd16);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    busy_manual = 1'b0;
    drain(300);

    // UART model with 20-cycle busy
    uart_en = 1'b1; rand_busy = 1'b0;
    n_pulse = 0;
    push_run(8'hA0, 3);
    drain(300);
    chk("model_pulses", n_pulse, 3);
    uart_en = 1'b0; busy_manual = 1'b1;
    repeat (2) tick();

    // Simultaneous push and pop
    push_run(8'h50, 5);
    tick();
    wr = 1'b1; data = 8'h55; q.push_back(8'h55); busy_manual = 1'b0;
    tick(); wr = 1'b0; busy_manual = 1'b1;
    chk("pushpop_count", {27'd0, count}, 32'd5);
    chk("pushpop_tx_wr", {31'd0, tx_wr}, 32'd1);
    push_run(8'h60, 11);
    chk("refill_full", {31'd0, full}, 32'd1);
    wr = 1'b1; data = 8'hEE; busy_manual = 1'b0;
    tick(); wr = 1'b0; busy_manual = 1'b1;
    chk("fullpop_count", {27'd0, count}, 32'd15);
    chk("fullpop_overflow", {31'd0, overflow}, 32'd1);
    chk("fullpop_tx_wr", {31'd0, tx_wr}, 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    busy_manual = 1'b0;
    drain(300);

    // 40 random bytes with random busy gaps, pointers wrap twice
    uart_en = 1'b1; rand_busy = 1'b1; sent = 0;
    for (int i = 0; i < 2000 && sent < 40; i++) begin
      if (!full) begin
        wr = 1'b1; data = 8'($urandom); q.push_back(data); sent++;
      end else begin
        wr = 1'b0;
      end
      tick();
    end
    wr = 1'b0;
    chk("wrap_sent", sent, 40);
    drain(1000);
    chk("wrap_no_overflow", {31'd0, overflow}, 32'd0);
    uart_en = 1'b0; busy_manual = 1'b1;
    repeat (2) tick();

    // Flush during HOLD at count 7
    push_run(8'h80, 8);
    tick();
    busy_manual = 1'b0;
    wait_txwr(10);
    chk("flush_pre_count", {27'd0, count}, 32'd7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_count", {27'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_tx_wr", {31'd0, tx_wr}, 32'd0);
    q.delete();
    repeat (20) tick();
    chk("flush_quiet", {31'd0, tx_wr}, 32'd0);

    // Reset while tx_wr is high
    busy_manual = 1'b1;
    push_run(8'hC0, 3);
    tick();
    busy_manual = 1'b0;
    wait_txwr(10);
    reset = 1'b1; tick();
    chk("mid_rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_count", {27'd0, count}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    q.delete();
    repeat (10) tick();
    chk("post_rst_quiet", {31'd0, tx_wr}, 32'd0);
    chk("post_rst_count", {27'd0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
